axi_read_resp_channel: RTL and testbench
========================================

Name: axi_read_resp_channel

Overview:
- Drives the AXI R channel of the AXI-to-APB bridge from the bottom (APB-to-AXI) read-data CDC FIFO.
- Queues accepted AR commands (ID, LEN), pops FIFO beats, tags each beat with RID and RLAST, and presents them through a 2-entry output buffer.
- Owns rinc_bottom generation. rinc_bottom never depends combinationally on R_READY.

Parameters:
- DATA_WIDTH, 32, width of R_DATA and of the FIFO data field.
- ID_WIDTH, 4, width of cmd_id and R_ID.
- CMD_DEPTH, 4, read-command queue depth; must be a power of 2 and at least 2.

Ports:
- AXI_clk  in  1  AXI-domain clock; all logic is on its rising edge.
- AXI_rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  AR accepted upstream; push {cmd_id, cmd_len}.
- cmd_ready  out  1  command queue not full.
- cmd_id  in  ID_WIDTH  ARID of the accepted read.
- cmd_len  in  8  ARLEN (beats minus 1).
- rdata_bottom  in  DATA_WIDTH+2  FIFO head, first-word-fall-through: [DATA_WIDTH+1:DATA_WIDTH] = RRESP, [DATA_WIDTH-1:0] = RDATA.
- rempty_bottom  in  1  FIFO empty; rdata_bottom is valid when low.
- rinc_bottom  out  1  FIFO pop strobe, one beat per high cycle.
- R_ID  out  ID_WIDTH  RID.
- R_DATA  out  DATA_WIDTH  RDATA.
- R_RESP  out  2  RRESP.
- R_LAST  out  1  RLAST.
- R_VALID  out  1  RVALID.
- R_READY  in  1  RREADY.
- busy  out  1  command queue non-empty or output buffer non-empty.

Behaviour:
- Reset (async assert, sync release): command queue empty, beat counter 0, output buffer empty.
  - R_VALID=0, R_LAST=0, R_ID/R_DATA/R_RESP=0, rinc_bottom=0, cmd_ready=1, busy=0.
- Command queue: circular buffer of CMD_DEPTH entries, rd/wr pointers with an extra wrap bit.
  - Push when cmd_valid & cmd_ready.
  - Pop in the cycle the final beat of the head command is taken from the FIFO.
  - cmd_ready=0 when full.
  - Push to a full queue is ignored and is a protocol error.
- Simultaneous push and pop on a full queue: the pop frees the slot the next cycle. cmd_ready is registered-full, so no push is accepted that cycle.
- Pop rule: rinc_bottom = !rempty_bottom & cmd_q_nonempty & (obuf_count < 2).
  - It is combinational from registered state and rempty_bottom only.
- Beat counter: 8-bit, counts pops for the head command.
  - last_beat = (beat_cnt == head_len).
  - On a pop with last_beat: beat_cnt <= 0 and the command is dequeued. The next command's beat 0 may pop the following cycle, with no bubble.
  - On a pop without last_beat: beat_cnt <= beat_cnt + 1.
- FIFO non-empty with no queued command: no pop, data is held. This is not an error.
- Output buffer: 2-entry FIFO of {id, resp, data, last}. Head drives R_* directly.
  - Push on rinc_bottom, with the entry captured from rdata_bottom, head_id and last_beat in the same cycle.
  - Pop on R_VALID & R_READY.
  - R_VALID = (obuf_count != 0).
  - Push and pop in the same cycle leave obuf_count unchanged.
  - Sustains 1 beat per cycle when R_READY is held high.
- AXI rule: once R_VALID=1, R_ID/R_DATA/R_RESP/R_LAST stay stable until the handshake.
- Latency: FIFO non-empty at cycle N with a command queued and the buffer empty gives rinc_bottom high at N and R_VALID high at N+1.
- RRESP is passed through per beat unmodified; SLVERR mid-burst does not truncate the burst.
- Reset mid-burst drops all queued commands and buffered beats immediately. FIFO contents are not flushed by this block.

Test Plan:
- cmd {id=3, len=0}, one FIFO word {OKAY, 0xDEADBEEF}, R_READY=1 -> rinc_bottom 1 cycle; next cycle R_VALID=1, R_ID=3, R_DATA=0xDEADBEEF, R_LAST=1; then R_VALID=0, busy=0.
- cmd {id=5, len=3}, 4 words preloaded, R_READY=1 -> 4 consecutive R_VALID beats; R_LAST only on beat 4; rinc_bottom high 4 consecutive cycles.
- Same burst with R_READY held 0 -> exactly 2 pops, rinc_bottom then 0, R_DATA stable. Release R_READY -> remaining 2 beats in order, no loss or duplication.
- Push 4 commands with CMD_DEPTH=4 -> cmd_ready=0. Cmds {id=1, len=1} and {id=2, len=0} back to back -> beats read ID 1, 1(last), 2(last) with no idle cycle between bursts.
- Beat 2 of a len=2 burst carries RRESP=2'b10 -> R_RESP=2'b10 on beat 2 only; R_LAST still on beat 3.
- Assert AXI_rst_n=0 mid-burst with 1 beat buffered -> R_VALID, rinc_bottom and busy go 0 asynchronously; cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_read_resp_channel.sv
// AXI R-channel driver for the AXI-to-APB bridge.
// Pairs read-data beats from the bottom CDC FIFO with queued AR commands,
// tags each beat with RID/RLAST and presents it through a 2-entry skid buffer.
// The FIFO pop strobe is derived from registered state and rempty_bottom only,
// so it never depends on R_READY within the same cycle.
module axi_read_resp_channel #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int CMD_DEPTH  = 4
) (
  input  logic                  AXI_clk,
  input  logic                  AXI_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH+1:0] rdata_bottom,
  input  logic                  rempty_bottom,
  output logic                  rinc_bottom,
  output logic [ID_WIDTH-1:0]   R_ID,
  output logic [DATA_WIDTH-1:0] R_DATA,
  output logic [1:0]            R_RESP,
  output logic                  R_LAST,
  output logic                  R_VALID,
  input  logic                  R_READY,
  output logic                  busy
);

  localparam int PW = $clog2(CMD_DEPTH);
  // Output buffer entry layout: {id, resp, data, last}
  localparam int EW = ID_WIDTH + 2 + DATA_WIDTH + 1;
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  // Command queue
  logic [PW:0]         wr_ptr_q, wr_ptr_d;
  logic [PW:0]         rd_ptr_q, rd_ptr_d;
  logic [ID_WIDTH-1:0] cmd_id_q  [CMD_DEPTH];
  logic [7:0]          cmd_len_q [CMD_DEPTH];
  logic                cmd_empty;
  logic                cmd_full;
  logic                cmd_push;
  logic                cmd_pop;
  logic [ID_WIDTH-1:0] head_id;
  logic [7:0]          head_len;

  // Beat counter for the head command
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       last_beat;

  // Output buffer
  logic [EW-1:0] obuf_q [2];
  logic          obuf_wr_q, obuf_wr_d;
  logic          obuf_rd_q, obuf_rd_d;
  logic [1:0]    obuf_cnt_q, obuf_cnt_d;
  logic          obuf_push;
  logic          obuf_pop;
  logic [EW-1:0] obuf_in;
  logic [EW-1:0] obuf_head;

  // Queue status, head command and pop strobe decode
  always_comb begin
    cmd_empty   = (wr_ptr_q == rd_ptr_q);
    cmd_full    = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {PW{1'b0}}});
    head_id     = cmd_id_q[rd_ptr_q[PW-1:0]];
    head_len    = cmd_len_q[rd_ptr_q[PW-1:0]];
    last_beat   = (beat_cnt_q == head_len);
    rinc_bottom = !rempty_bottom && !cmd_empty && (obuf_cnt_q < 2'd2);
    cmd_push    = cmd_valid && !cmd_full;
    cmd_pop     = rinc_bottom && last_beat;
    obuf_push   = rinc_bottom;
    obuf_pop    = R_VALID && R_READY;
    obuf_in     = {head_id, rdata_bottom, last_beat};
  end

  // Next-state for pointers, beat counter and buffer occupancy
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_cnt_d = beat_cnt_q;
    obuf_wr_d  = obuf_wr_q;
    obuf_rd_d  = obuf_rd_q;
    obuf_cnt_d = obuf_cnt_q;
    if (cmd_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (cmd_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (rinc_bottom) begin
      // Last beat rolls straight into beat 0 of the next command, no bubble
      beat_cnt_d = last_beat ? 8'd0 : beat_cnt_q + 8'd1;
    end
    if (obuf_push) obuf_wr_d = ~obuf_wr_q;
    if (obuf_pop)  obuf_rd_d = ~obuf_rd_q;
    if (obuf_push && !obuf_pop)      obuf_cnt_d = obuf_cnt_q + 2'd1;
    else if (!obuf_push && obuf_pop) obuf_cnt_d = obuf_cnt_q - 2'd1;
  end

  // Control state registers
  always_ff @(posedge AXI_clk or negedge AXI_rst_n) begin
    if (!AXI_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_cnt_q <= '0;
      obuf_wr_q  <= 1'b0;
      obuf_rd_q  <= 1'b0;
      obuf_cnt_q <= 2'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      obuf_wr_q  <= obuf_wr_d;
      obuf_rd_q  <= obuf_rd_d;
      obuf_cnt_q <= obuf_cnt_d;
    end
  end

  // Command storage; written only when a slot is free
  always_ff @(posedge AXI_clk or negedge AXI_rst_n) begin
    if (!AXI_rst_n) begin
      for (int i = 0; i < CMD_DEPTH; i++) begin
        cmd_id_q[i]  <= '0;
        cmd_len_q[i] <= '0;
      end
    end else if (cmd_push) begin
      cmd_id_q[wr_ptr_q[PW-1:0]]  <= cmd_id;
      cmd_len_q[wr_ptr_q[PW-1:0]] <= cmd_len;
    end
  end

  // Output buffer storage; entries are cleared so R_* read zero after reset
  always_ff @(posedge AXI_clk or negedge AXI_rst_n) begin
    if (!AXI_rst_n) begin
      obuf_q[0] <= '0;
      obuf_q[1] <= '0;
    end else if (obuf_push) begin
      obuf_q[obuf_wr_q] <= obuf_in;
    end
  end

  // Buffer head drives the R channel directly, so fields hold until handshake
  always_comb begin
    obuf_head = obuf_q[obuf_rd_q];
    R_ID      = obuf_head[EW-1 -: ID_WIDTH];
    R_RESP    = obuf_head[DATA_WIDTH+2 -: 2];
    R_DATA    = obuf_head[DATA_WIDTH:1];
    R_LAST    = obuf_head[0];
    R_VALID   = (obuf_cnt_q != 2'd0);
    cmd_ready = !cmd_full;
    busy      = !cmd_empty || (obuf_cnt_q != 2'd0);
  end

endmodule

// File: tb/tb_axi_read_resp_channel.sv
// Bench for axi_read_resp_channel: a queue-based FIFO environment, a burst-level
// reference model of the R stream, and one task per scenario.
module tb_axi_read_resp_channel;

  logic        AXI_clk = 1'b0;
  logic        AXI_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_id;
  logic [7:0]  cmd_len;
  logic [33:0] rdata_bottom;
  logic        rempty_bottom;
  logic        rinc_bottom;
  logic [3:0]  R_ID;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP;
  logic        R_LAST;
  logic        R_VALID;
  logic        R_READY;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [3:0] id; logic [7:0] len; } cmd_t;
  typedef struct { logic [1:0] resp; logic [31:0] data; } word_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; logic [31:0] data; logic last; } beat_t;

  word_t fifo_q[$];   // bottom CDC FIFO contents
  cmd_t  m_cmds[$];   // commands accepted but not fully fetched
  beat_t exp_q[$];    // beats fetched but not yet handed over on R
  beat_t hs_log[$];   // observed R handshakes
  int    m_beat = 0;
  int    hs_cnt = 0;

  logic        prev_stall = 1'b0;
  logic [3:0]  prev_id;
  logic [31:0] prev_data;
  logic [1:0]  prev_resp;
  logic        prev_last;

  axi_read_resp_channel #(.DATA_WIDTH(32), .ID_WIDTH(4), .CMD_DEPTH(4)) dut (
    .AXI_clk(AXI_clk), .AXI_rst_n(AXI_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_len(cmd_len),
    .rdata_bottom(rdata_bottom), .rempty_bottom(rempty_bottom), .rinc_bottom(rinc_bottom),
    .R_ID(R_ID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_LAST(R_LAST),
    .R_VALID(R_VALID), .R_READY(R_READY), .busy(busy)
  );

  always #5 AXI_clk = ~AXI_clk;

  task automatic drive_fifo();
    rempty_bottom = (fifo_q.size() == 0);
    rdata_bottom  = (fifo_q.size() == 0) ? 34'd0 : {fifo_q[0].resp, fifo_q[0].data};
  endtask

  // Model and continuous checks, evaluated mid-cycle for the coming edge
  always begin : monitor
    logic  do_pop;
    logic  accept;
    logic  exp_rinc;
    logic  exp_busy;
    beat_t b;
    beat_t obs;
    @(negedge AXI_clk);
    do_pop = 1'b0;
    if (!AXI_rst_n) begin
      m_cmds.delete();
      exp_q.delete();
      m_beat     = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if ({R_VALID, R_ID, R_DATA, R_RESP, R_LAST} !== {1'b1, prev_id, prev_data, prev_resp, prev_last}) begin
          errors++;
          $display("FAIL r_stable: got v=%b id=%h d=%h r=%h l=%b want v=1 id=%h d=%h r=%h l=%b",
                   R_VALID, R_ID, R_DATA, R_RESP, R_LAST, prev_id, prev_data, prev_resp, prev_last);
        end
      end
      checks++;
      if (R_VALID !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL r_valid: got %b want %b", R_VALID, exp_q.size() != 0);
      end
      checks++;
      if (cmd_ready !== (m_cmds.size() < 4)) begin
        errors++;
        $display("FAIL cmd_ready: got %b want %b", cmd_ready, m_cmds.size() < 4);
      end
      exp_busy = (m_cmds.size() != 0) || (exp_q.size() != 0);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy: got %b want %b", busy, exp_busy);
      end
      exp_rinc = (fifo_q.size() != 0) && (m_cmds.size() != 0) && (exp_q.size() < 2);
      checks++;
      if (rinc_bottom !== exp_rinc) begin
        errors++;
        $display("FAIL rinc_bottom: got %b want %b", rinc_bottom, exp_rinc);
      end
      accept = cmd_valid && (m_cmds.size() < 4);
      if (R_VALID && R_READY && exp_q.size() != 0) begin
        b = exp_q.pop_front();
        obs.id = R_ID; obs.resp = R_RESP; obs.data = R_DATA; obs.last = R_LAST;
        hs_log.push_back(obs);
        hs_cnt++;
        checks++;
        if ({R_ID, R_RESP, R_DATA, R_LAST} !== {b.id, b.resp, b.data, b.last}) begin
          errors++;
          $display("FAIL r_beat: got id=%h r=%h d=%h l=%b want id=%h r=%h d=%h l=%b",
                   R_ID, R_RESP, R_DATA, R_LAST, b.id, b.resp, b.data, b.last);
        end
      end
      if (rinc_bottom && fifo_q.size() != 0 && m_cmds.size() != 0) begin
        do_pop = 1'b1;
        b.id   = m_cmds[0].id;
        b.resp = fifo_q[0].resp;
        b.data = fifo_q[0].data;
        b.last = (m_beat == int'(m_cmds[0].len));
        exp_q.push_back(b);
        if (b.last) begin
          m_cmds.delete(0);
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
      if (accept) m_cmds.push_back('{id: cmd_id, len: cmd_len});
      prev_stall = R_VALID && !R_READY;
      prev_id = R_ID; prev_data = R_DATA; prev_resp = R_RESP; prev_last = R_LAST;
    end
    @(posedge AXI_clk);
    #1;
    if (do_pop && fifo_q.size() != 0) begin
      fifo_q.delete(0);
      drive_fifo();
    end
  end

  // All scenario tasks start and end 2 time units after a rising edge
  task automatic tick();
    @(posedge AXI_clk);
    #2;
  endtask

  task automatic push_cmd(input logic [3:0] id, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_word(input logic [1:0] resp, input logic [31:0] data);
    fifo_q.push_back('{resp: resp, data: data});
    drive_fifo();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i = 0;
    while (i < budget && !(exp_q.size() == 0 && m_cmds.size() == 0 && fifo_q.size() == 0)) begin
      tick();
      i++;
    end
    checks++;
    if (i >= budget) begin
      errors++;
      $display("FAIL %s_timeout: got pending=%0d/%0d/%0d want 0/0/0", name, exp_q.size(), m_cmds.size(), fifo_q.size());
    end
    checks++;
    if ({busy, R_VALID} !== 2'b00) begin
      errors++;
      $display("FAIL %s_idle: got busy=%b r_valid=%b want 0 0", name, busy, R_VALID);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({R_VALID, R_LAST, R_ID, R_DATA, R_RESP, rinc_bottom, cmd_ready, busy} !== {1'b0, 1'b0, 4'd0, 32'd0, 2'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b l=%b id=%h d=%h r=%h inc=%b rdy=%b busy=%b want 0 0 0 0 0 0 1 0",
               R_VALID, R_LAST, R_ID, R_DATA, R_RESP, rinc_bottom, cmd_ready, busy);
    end
    repeat (2) @(posedge AXI_clk);
    #2;
    AXI_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    R_READY = 1'b1;
    push_cmd(4'd3, 8'd0);
    push_word(2'b00, 32'hDEADBEEF);
    #1;
    checks++;
    if (rinc_bottom !== 1'b1) begin
      errors++;
      $display("FAIL single_rinc: got %b want 1", rinc_bottom);
    end
    tick();
    checks++;
    if ({rinc_bottom, R_VALID, R_ID, R_DATA, R_RESP, R_LAST} !== {1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL single_beat: got inc=%b v=%b id=%h d=%h r=%h l=%b want 0 1 3 deadbeef 0 1",
               rinc_bottom, R_VALID, R_ID, R_DATA, R_RESP, R_LAST);
    end
    tick();
    checks++;
    if ({R_VALID, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_done: got v=%b busy=%b want 0 0", R_VALID, busy);
    end
  endtask

  task automatic test_burst();
    int cnt = 0;
    int first = -1;
    int last = -1;
    R_READY = 1'b1;
    for (int i = 0; i < 4; i++) push_word(2'b00, 32'h5000_0000 + i);
    tick();
    tick();
    checks++;
    if (rinc_bottom !== 1'b0) begin
      errors++;
      $display("FAIL burst_hold_no_cmd: got %b want 0", rinc_bottom);
    end
    push_cmd(4'd5, 8'd3);
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rinc_bottom) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
      tick();
    end
    checks++;
    if (cnt != 4 || last - first + 1 != 4) begin
      errors++;
      $display("FAIL burst_rinc_run: got count=%0d span=%0d want 4 4", cnt, last - first + 1);
    end
    wait_idle(20, "burst");
  endtask

  task automatic test_backpressure();
    int cnt = 0;
    int hs0;
    R_READY = 1'b0;
    for (int i = 0; i < 4; i++) push_word(2'b00, 32'hB000_0000 + i);
    push_cmd(4'd5, 8'd3);
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rinc_bottom) cnt++;
      tick();
    end
    checks++;
    if (cnt != 2) begin
      errors++;
      $display("FAIL bp_pop_count: got %0d want 2", cnt);
    end
    checks++;
    if ({R_VALID, R_DATA} !== {1'b1, 32'hB000_0000}) begin
      errors++;
      $display("FAIL bp_head: got v=%b d=%h want 1 b0000000", R_VALID, R_DATA);
    end
    hs0 = hs_cnt;
    R_READY = 1'b1;
    wait_idle(20, "bp");
    checks++;
    if (hs_cnt - hs0 != 4) begin
      errors++;
      $display("FAIL bp_beats: got %0d want 4", hs_cnt - hs0);
    end
  endtask

  task automatic test_full();
    R_READY = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(4'(10 + i), 8'd0);
    checks++;
    if ({cmd_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL full_ready: got rdy=%b busy=%b want 0 1", cmd_ready, busy);
    end
    for (int i = 0; i < 4; i++) push_word(2'b01, 32'hF000_0000 + i);
    R_READY = 1'b1;
    wait_idle(20, "full");
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_release: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] eid[3];
    logic       elast[3];
    int cnt = 0;
    int first = -1;
    int last = -1;
    eid = '{4'd1, 4'd1, 4'd2};
    elast = '{1'b0, 1'b1, 1'b1};
    R_READY = 1'b1;
    hs_log.delete();
    for (int i = 0; i < 3; i++) push_word(2'b00, 32'hC000_0000 + i);
    push_cmd(4'd1, 8'd1);
    push_cmd(4'd2, 8'd0);
    for (int i = 0; i < 8; i++) begin
      #1;
      if (R_VALID) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
      tick();
    end
    checks++;
    if (cnt != 3 || last - first + 1 != 3) begin
      errors++;
      $display("FAIL b2b_valid_run: got count=%0d span=%0d want 3 3", cnt, last - first + 1);
    end
    checks++;
    if (hs_log.size() != 3) begin
      errors++;
      $display("FAIL b2b_beats: got %0d want 3", hs_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({hs_log[i].id, hs_log[i].last} !== {eid[i], elast[i]}) begin
          errors++;
          $display("FAIL b2b_beat%0d: got id=%h l=%b want id=%h l=%b", i, hs_log[i].id, hs_log[i].last, eid[i], elast[i]);
        end
      end
    end
    wait_idle(20, "b2b");
  endtask

  task automatic test_slverr();
    logic [1:0] eresp[3];
    logic       elast[3];
    eresp = '{2'b00, 2'b10, 2'b00};
    elast = '{1'b0, 1'b0, 1'b1};
    R_READY = 1'b1;
    hs_log.delete();
    for (int i = 0; i < 3; i++) push_word(eresp[i], $urandom());
    push_cmd(4'd7, 8'd2);
    wait_idle(20, "slverr");
    checks++;
    if (hs_log.size() != 3) begin
      errors++;
      $display("FAIL slverr_beats: got %0d want 3", hs_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({hs_log[i].resp, hs_log[i].last} !== {eresp[i], elast[i]}) begin
          errors++;
          $display("FAIL slverr_beat%0d: got r=%h l=%b want r=%h l=%b", i, hs_log[i].resp, hs_log[i].last, eresp[i], elast[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int hs0 = hs_cnt;
    int total = 0;
    for (int c = 0; c < 40; c++) begin
      int len = $urandom_range(0, 5);
      int guard = 0;
      while (m_cmds.size() >= 4 && guard < 200) begin
        R_READY = 1'($urandom_range(0, 1));
        tick();
        guard++;
      end
      push_cmd(4'($urandom_range(0, 15)), 8'(len));
      total += len + 1;
      for (int b = 0; b <= len; b++) begin
        push_word(2'($urandom_range(0, 3)), $urandom());
        if ($urandom_range(0, 1) == 1) begin
          R_READY = 1'($urandom_range(0, 1));
          tick();
        end
      end
    end
    R_READY = 1'b1;
    wait_idle(600, "random");
    checks++;
    if (hs_cnt - hs0 != total) begin
      errors++;
      $display("FAIL random_beats: got %0d want %0d", hs_cnt - hs0, total);
    end
  endtask

  task automatic test_reset_mid();
    R_READY = 1'b0;
    push_cmd(4'd9, 8'd3);
    push_word(2'b00, 32'h0000_1234);
    tick();
    tick();
    checks++;
    if ({R_VALID, busy} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_pre: got v=%b busy=%b want 1 1", R_VALID, busy);
    end
    #1;
    AXI_rst_n = 1'b0;
    #1;
    checks++;
    if ({R_VALID, rinc_bottom, busy, R_DATA} !== {1'b0, 1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL rstmid_async: got v=%b inc=%b busy=%b d=%h want 0 0 0 0", R_VALID, rinc_bottom, busy, R_DATA);
    end
    @(posedge AXI_clk);
    #2;
    fifo_q.delete();
    drive_fifo();
    AXI_rst_n = 1'b1;
    tick();
    checks++;
    if ({cmd_ready, busy, R_VALID} !== 3'b100) begin
      errors++;
      $display("FAIL rstmid_release: got rdy=%b busy=%b v=%b want 1 0 0", cmd_ready, busy, R_VALID);
    end
  endtask

  initial begin
    AXI_rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_id    = 4'd0;
    cmd_len   = 8'd0;
    R_READY   = 1'b0;
    drive_fifo();
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_full();
    test_back_to_back();
    test_slverr();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion want completion before 400000");
    $fatal(1, "watchdog expired");
  end

endmodule
